// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo
// Receive-side first-word-fall-through buffer placed directly after the UART
// receiver. Each completed frame is captured on a one-cycle wr_valid strobe
// as {parity_err, stop_err, data[7:0]}. The frame is held until the consumer
// takes it through the rd_valid/rd_ready handshake.
//
// Handshake: rd_valid is high while the FIFO holds at least one entry, and
// rd_* then shows the head entry. An entry is consumed on a rising edge where
// rd_valid and rd_ready are both 1. rd_ready has no effect while rd_valid is
// 0. The write side has no back-pressure. A frame that arrives while the FIFO
// is full and no pop happens in the same cycle is lost, and overflow is set.
//
// Ports:
//   baud_clk        system clock, rising edge
//   reset           asynchronous active-low reset
//   wr_valid        one-cycle strobe per received frame
//   wr_data         received byte
//   wr_parity_err   parity error of the frame
//   wr_stop_err     stop error of the frame
//   rd_ready        consumer accepts the head entry
//   rd_valid        head entry present
//   rd_data         head byte (0 while empty)
//   rd_parity_err   head parity flag (0 while empty)
//   rd_stop_err     head stop flag (0 while empty)
//   fill_count      number of stored entries, 0..DEPTH
//   full, empty     fill status
//   overflow        sticky lost-frame flag
//   clr_overflow    synchronous clear of overflow
//   err_drop_count  saturating count of errored frames discarded (DROP_ERR=1)
//
// DEPTH must be a power of two, at least 2, and equal to 2**ADDR_W.

module rx_byte_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int DROP_ERR = 0
) (
  input  logic              baud_clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  input  logic              wr_parity_err,
  input  logic              wr_stop_err,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              rd_parity_err,
  output logic              rd_stop_err,
  output logic [ADDR_W:0]   fill_count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [7:0]        err_drop_count
);

  localparam logic            drop_en  = (DROP_ERR != 0);
  localparam logic [ADDR_W:0] full_cnt = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] cnt_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ptr_one = ADDR_W'(1);

  // Storage is deliberately not reset. The empty-gating on rd_* hides any
  // stale contents.
  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [9:0]        head;

  logic frame_err;
  logic drop_frame;
  logic push;
  logic pop;
  logic ovf_set;

  assign frame_err  = wr_parity_err | wr_stop_err;
  assign drop_frame = drop_en & wr_valid & frame_err;

  assign empty    = (fill_count == '0);
  assign full     = (fill_count == full_cnt);
  assign rd_valid = ~empty;

  assign pop  = rd_valid & rd_ready;
  // When the FIFO is full, a push in the same cycle as a pop reuses the slot
  // being freed.
  assign push    = wr_valid & ~drop_frame & (~full | pop);
  // A frame removed by the error filter is never a lost frame.
  assign ovf_set = wr_valid & ~drop_frame & full & ~pop;

  assign head          = mem[rd_ptr];
  assign rd_data       = empty ? 8'h00 : head[7:0];
  assign rd_stop_err   = empty ? 1'b0  : head[8];
  assign rd_parity_err = empty ? 1'b0  : head[9];

  always_ff @(posedge baud_clk) begin
    if (push) begin
      mem[wr_ptr] <= {wr_parity_err, wr_stop_err, wr_data};
    end
  end

  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop)  rd_ptr <= rd_ptr + ptr_one;
      case ({push, pop})
        2'b10:   fill_count <= fill_count + cnt_one;
        2'b01:   fill_count <= fill_count - cnt_one;
        default: fill_count <= fill_count;
      endcase
    end
  end

  // A new loss in the same cycle as a clear takes priority over the clear.
  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      err_drop_count <= '0;
    end else if (drop_frame && err_drop_count != 8'hFF) begin
      err_drop_count <= err_drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
module tb_rx_byte_fifo;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic baud_clk = 1'b0;
  logic reset    = 1'b0;
  always #5 baud_clk = ~baud_clk;

  // ---------------- DUT with DROP_ERR = 0 ----------------
  logic       wr_valid = 0, wr_parity_err = 0, wr_stop_err = 0;
  logic [7:0] wr_data = 0;
  logic       rd_ready = 0, clr_overflow = 0;
  logic       rd_valid, rd_parity_err, rd_stop_err, full, empty, overflow;
  logic [7:0] rd_data, err_drop_count;
  logic [4:0] fill_count;

  rx_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .DROP_ERR(0)) u_dut (
    .baud_clk(baud_clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_parity_err(wr_parity_err), .wr_stop_err(wr_stop_err),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_parity_err(rd_parity_err), .rd_stop_err(rd_stop_err),
    .fill_count(fill_count), .full(full), .empty(empty),
    .overflow(overflow), .clr_overflow(clr_overflow),
    .err_drop_count(err_drop_count)
  );

  // ---------------- DUT with DROP_ERR = 1 ----------------
  logic       d_wr_valid = 0, d_wr_parity_err = 0, d_wr_stop_err = 0;
  logic [7:0] d_wr_data = 0;
  logic       d_rd_ready = 0, d_clr_overflow = 0;
  logic       d_rd_valid, d_rd_parity_err, d_rd_stop_err, d_full, d_empty, d_overflow;
  logic [7:0] d_rd_data, d_err_drop_count;
  logic [4:0] d_fill_count;

  rx_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .DROP_ERR(1)) u_dut_drop (
    .baud_clk(baud_clk), .reset(reset),
    .wr_valid(d_wr_valid), .wr_data(d_wr_data),
    .wr_parity_err(d_wr_parity_err), .wr_stop_err(d_wr_stop_err),
    .rd_ready(d_rd_ready), .rd_valid(d_rd_valid), .rd_data(d_rd_data),
    .rd_parity_err(d_rd_parity_err), .rd_stop_err(d_rd_stop_err),
    .fill_count(d_fill_count), .full(d_full), .empty(d_empty),
    .overflow(d_overflow), .clr_overflow(d_clr_overflow),
    .err_drop_count(d_err_drop_count)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       pe;
    logic       se;
    logic       rr;
    logic       exp_rv;
    logic [7:0] exp_rd;
    logic       exp_pe;
    logic       exp_se;
    logic [4:0] exp_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic push0(input logic [7:0] d, input logic pe, input logic se);
    wr_valid = 1; wr_data = d; wr_parity_err = pe; wr_stop_err = se;
    tick();
    wr_valid = 0; wr_parity_err = 0; wr_stop_err = 0;
  endtask

  task automatic push1(input logic [7:0] d, input logic pe, input logic se);
    d_wr_valid = 1; d_wr_data = d; d_wr_parity_err = pe; d_wr_stop_err = se;
    tick();
    d_wr_valid = 0; d_wr_parity_err = 0; d_wr_stop_err = 0;
  endtask

  task automatic drain0();
    logic [9:0] e;
    for (int i = 0; i < DEPTH + 2 && rd_valid; i++) begin
      if (exp_q.size() == 0) begin
        chk("drain_extra_entry", {22'd0, rd_parity_err, rd_stop_err, rd_data}, 32'h0);
        errors = errors;
      end else begin
        e = exp_q.pop_front();
        chk("drain_head", {22'd0, rd_parity_err, rd_stop_err, rd_data}, {22'd0, e});
      end
      rd_ready = 1;
      tick();
      rd_ready = 0;
    end
    chk("drain_q_left", exp_q.size(), 0);
    chk("drain_empty", empty, 1);
    chk("drain_rd_valid", rd_valid, 0);
    chk("drain_fill", fill_count, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    //            wv  wd     pe se rr   rv  rd     rpe rse fc
    vecs.push_back('{1, 8'h55, 0, 0, 0,  1, 8'h55, 0, 0, 5'd1});
    vecs.push_back('{1, 8'hA3, 0, 0, 0,  1, 8'h55, 0, 0, 5'd2});
    vecs.push_back('{1, 8'h0F, 0, 0, 0,  1, 8'h55, 0, 0, 5'd3});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  1, 8'hA3, 0, 0, 5'd2});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  1, 8'h0F, 0, 0, 5'd1});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 5'd0});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 5'd0});
    vecs.push_back('{1, 8'h3C, 1, 0, 0,  1, 8'h3C, 1, 0, 5'd1});
    vecs.push_back('{1, 8'h81, 0, 1, 0,  1, 8'h3C, 1, 0, 5'd2});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  1, 8'h81, 0, 1, 5'd1});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 5'd0});
    vecs.push_back('{1, 8'h12, 0, 0, 1,  1, 8'h12, 0, 0, 5'd1});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 5'd0});
    vecs.push_back('{1, 8'h5A, 0, 0, 1,  1, 8'h5A, 0, 0, 5'd1});
    vecs.push_back('{1, 8'h6B, 0, 0, 1,  1, 8'h6B, 0, 0, 5'd1});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 5'd0});
    vecs.push_back('{0, 8'hFF, 1, 1, 0,  0, 8'h00, 0, 0, 5'd0});

    do_reset();
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_fill", fill_count, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_drop_cnt", d_err_drop_count, 0);

    // Table-driven single-cycle vectors
    foreach (vecs[i]) begin
      wr_valid = vecs[i].wv; wr_data = vecs[i].wd;
      wr_parity_err = vecs[i].pe; wr_stop_err = vecs[i].se;
      rd_ready = vecs[i].rr;
      tick();
      chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_rv);
      chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_rd_pe", i), rd_parity_err, vecs[i].exp_pe);
      chk($sformatf("vec%0d_rd_se", i), rd_stop_err, vecs[i].exp_se);
      chk($sformatf("vec%0d_fill", i), fill_count, vecs[i].exp_fc);
      chk($sformatf("vec%0d_empty", i), empty, (vecs[i].exp_fc == 0));
      chk($sformatf("vec%0d_full", i), full, (vecs[i].exp_fc == 5'd16));
    end
    wr_valid = 0; rd_ready = 0; wr_parity_err = 0; wr_stop_err = 0;
    chk("nodrop_cnt_zero", err_drop_count, 0);

    // Fill to full, overflow, simultaneous push/pop while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push0(8'(i), 0, 0);
      exp_q.push_back({2'b00, 8'(i)});
    end
    chk("full_flag", full, 1);
    chk("full_fill", fill_count, 16);
    chk("full_no_ovf", overflow, 0);
    push0(8'hEE, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_fill", fill_count, 16);
    chk("ovf_head", rd_data, 8'h00);
    clr_overflow = 1; tick(); clr_overflow = 0;
    chk("ovf_clr", overflow, 0);

    chk("simul_head_before", {22'd0, rd_parity_err, rd_stop_err, rd_data}, {22'd0, exp_q[0]});
    wr_valid = 1; wr_data = 8'h77; rd_ready = 1;
    tick();
    wr_valid = 0; rd_ready = 0;
    void'(exp_q.pop_front());
    exp_q.push_back(10'h077);
    chk("simul_fill", fill_count, 16);
    chk("simul_no_ovf", overflow, 0);
    chk("simul_head_after", rd_data, 8'h01);

    // Set and clear in the same cycle: the set wins
    wr_valid = 1; wr_data = 8'hE1; clr_overflow = 1;
    tick();
    wr_valid = 0; clr_overflow = 0;
    chk("ovf_set_beats_clr", overflow, 1);
    clr_overflow = 1; tick(); clr_overflow = 0;
    chk("ovf_clr2", overflow, 0);
    drain0();

    // Second full pass after both pointers have wrapped
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] b;
      b = 8'h90 + 8'(i);
      push0(b, i[0], i[1]);
      exp_q.push_back({i[0], i[1], b});
    end
    chk("wrap_full", full, 1);
    drain0();
    chk("wrap_no_ovf", overflow, 0);

    // DROP_ERR = 1 instance
    push1(8'h3C, 1, 0);
    chk("drop_not_stored", d_empty, 1);
    chk("drop_cnt1", d_err_drop_count, 1);
    for (int i = 0; i < DEPTH; i++) push1(8'h40 + 8'(i), 0, 0);
    chk("drop_full", d_full, 1);
    chk("drop_head", d_rd_data, 8'h40);
    push1(8'hBB, 0, 1);
    chk("drop_full_no_ovf", d_overflow, 0);
    chk("drop_cnt2", d_err_drop_count, 2);
    chk("drop_fill16", d_fill_count, 16);
    for (int i = 0; i < 300; i++) push1(8'(i), 1, 1);
    chk("drop_cnt_sat", d_err_drop_count, 255);
    chk("drop_sat_no_ovf", d_overflow, 0);
    chk("drop_sat_fill", d_fill_count, 16);

    // Asynchronous reset mid-cycle with three entries stored
    push0(8'h11, 0, 0);
    push0(8'h22, 0, 0);
    push0(8'h33, 0, 0);
    chk("pre_rst_fill", fill_count, 3);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_fill", fill_count, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_drop_cnt", d_err_drop_count, 0);
    chk("arst_drop_fill", d_fill_count, 0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
Name: rx_byte_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed frame (8-bit data plus parity and stop error flags) on a one-cycle strobe and holds it in a first-word-fall-through FIFO until the consumer (host logic or a command parser) accepts it through a valid/ready handshake. It provides fill status, a sticky overflow flag and optional discard of errored frames.

Parameters:
DEPTH, 16, number of frame entries; must be a power of 2 and at least 2
ADDR_W, 4, log2(DEPTH); pointer width
DROP_ERR, 0, 1 = discard frames whose parity or stop error is set; 0 = store them with their flags

Ports:
baud_clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
wr_valid  in  1  one-cycle pulse per completed received frame
wr_data  in  8  received byte, qualified by wr_valid
wr_parity_err  in  1  parity error for the frame, qualified by wr_valid
wr_stop_err  in  1  stop error for the frame, qualified by wr_valid
rd_ready  in  1  consumer accepts the head entry
rd_valid  out  1  head entry present (FIFO not empty)
rd_data  out  8  head byte
rd_parity_err  out  1  head parity-error flag
rd_stop_err  out  1  head stop-error flag
fill_count  out  ADDR_W+1  entries stored, 0..DEPTH
full  out  1  fill_count == DEPTH
empty  out  1  fill_count == 0
overflow  out  1  sticky flag: a frame was lost because the FIFO was full
clr_overflow  in  1  synchronous clear of overflow
err_drop_count  out  8  saturating count of frames discarded by DROP_ERR

Behaviour:
- Reset (reset = 0, asynchronous): read/write pointers = 0, fill_count = 0, empty = 1, full = 0, rd_valid = 0, overflow = 0, err_drop_count = 0. rd_data and the rd_*_err outputs read 0 while empty. The storage array is not reset. Reset asserted mid-operation discards all contents immediately.
- Entry format: {parity_err, stop_err, data[7:0]}, 10 bits.
- Push condition: wr_valid = 1 AND NOT (DROP_ERR = 1 AND (wr_parity_err OR wr_stop_err)) AND (full = 0 OR pop in the same cycle).
- Pop condition: rd_valid = 1 AND rd_ready = 1.
- FWFT: rd_data and the rd flags are combinational from the storage entry at the read pointer. A pushed frame appears on rd_* in the cycle after wr_valid (write-to-read latency = 1). A pop advances the head on the next edge.
- Simultaneous push and pop:
  - when not empty: both occur and fill_count is unchanged.
  - when full: both occur; no overflow.
  - when empty: the pop cannot occur (rd_valid = 0); only the push occurs.
- Overflow: wr_valid = 1 while full with no pop: the frame is discarded, pointers and contents are unchanged, and overflow is set to 1 on the next edge. clr_overflow = 1 clears it. If a set and a clear occur in the same cycle, the set wins.
- Frames dropped by DROP_ERR never count toward overflow, even when full.
- DROP_ERR = 1: each errored wr_valid increments err_drop_count, saturating at 255. With DROP_ERR = 0, err_drop_count stays 0.
- Pointers are ADDR_W bits and wrap modulo DEPTH. fill_count is tracked separately with (ADDR_W+1) bits to distinguish full from empty.
- rd_ready while empty has no effect. wr_* inputs are ignored when wr_valid = 0.

Test Plan:
- Reset, then push 0x55, 0xA3, 0x0F with rd_ready = 0 -> fill_count = 3; rd_data = 0x55 one cycle after the first push; draining with rd_ready = 1 gives 0x55, 0xA3, 0x0F in order, then empty = 1 and rd_valid = 0.
- DEPTH = 16: push 0x00..0x0F -> full = 1, fill_count = 16. Push 0xEE -> overflow = 1, contents unchanged. Drain yields 0x00..0x0F; clr_overflow -> overflow = 0.
- Full FIFO, same-cycle wr_valid (0x77) and rd_ready -> head 0x00 leaves, 0x77 stored at the tail, fill_count stays 16, no overflow. Also cover pointer wrap after more than 16 pushes.
- DROP_ERR = 0: push 0x3C with wr_parity_err = 1 -> rd_parity_err = 1 with rd_data = 0x3C. DROP_ERR = 1: same stimulus -> not stored, err_drop_count = 1. Send 300 errored frames -> err_drop_count = 255.
- Empty FIFO, wr_valid with rd_ready = 1 held -> entry is stored and visible next cycle (fill_count = 1), then popped on the following edge.
- Three entries stored, assert reset low mid-cycle -> outputs go to reset values immediately (empty = 1, fill_count = 0, overflow = 0) without waiting for a clock edge.
